// File: rtl/lab1_imul_operand_sorter_if.sv
// Request/response stream bundle for the multiplier operand sorter.
// Valid/ready handshake on both streams: a transfer happens on a posedge where val && rdy are both high.
// The sender holds val and msg steady until that edge; rdy may be computed without looking at val.
interface lab1_imul_operand_sorter_if;
   logic        istream_val;
   logic        istream_rdy;
   logic [63:0] istream_msg;
   logic        ostream_val;
   logic        ostream_rdy;
   logic [63:0] ostream_msg;

   modport master (
      output istream_val, istream_msg, ostream_rdy,
      input  istream_rdy, ostream_val, ostream_msg
   );

   modport slave (
      input  istream_val, istream_msg, ostream_rdy,
      output istream_rdy, ostream_val, ostream_msg
   );
endinterface

// File: rtl/lab1_imul_operand_sorter.sv
// Orders {a,b} so the operand with the higher leading one comes first, then queues
// the ordered pair in a small circular FIFO in front of the variable-latency multiplier.
module lab1_imul_operand_sorter #(
   parameter int NENTRIES = 2,
   parameter bit SWAP_EN  = 1'b1
) (
   input  logic                         clk,
   input  logic                         reset,
   lab1_imul_operand_sorter_if.slave    s,
   output logic [$clog2(NENTRIES):0]    occupancy,
   output logic [15:0]                  swap_count
);

   localparam int PW = $clog2(NENTRIES);
   localparam int OW = PW + 1;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [63:0]   mem [NENTRIES];

   logic [31:0] in_a;
   logic [31:0] in_b;
   logic        do_swap;
   logic [63:0] ordered;
   logic        enq;
   logic        deq;
   logic        full;
   logic        empty;

   function automatic logic signed [6:0] msb_idx(input logic [31:0] x);
      msb_idx = -7'sd1;
      for (int i = 0; i < 32; i++) begin
         if (x[i]) msb_idx = 7'(i);
      end
   endfunction

   function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
      bump = (p == PW'(NENTRIES - 1)) ? '0 : p + PW'(1);
   endfunction

   assign in_a    = s.istream_msg[63:32];
   assign in_b    = s.istream_msg[31:0];
   assign do_swap = SWAP_EN && (msb_idx(in_b) > msb_idx(in_a));
   assign ordered = do_swap ? {in_b, in_a} : s.istream_msg;

   assign full  = (occupancy == OW'(NENTRIES));
   assign empty = (occupancy == '0);

   // Ready is gated by reset so nothing is accepted while the block is held in reset.
   assign s.istream_rdy = reset && !full;
   assign s.ostream_val = !empty;
   assign s.ostream_msg = empty ? 64'h0 : mem[rd_ptr];

   assign enq = s.istream_val && s.istream_rdy;
   assign deq = s.ostream_val && s.ostream_rdy;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         occupancy  <= '0;
         swap_count <= '0;
      end else begin
         if (enq) wr_ptr <= bump(wr_ptr);
         if (deq) rd_ptr <= bump(rd_ptr);
         case ({enq, deq})
            2'b10:   occupancy <= occupancy + OW'(1);
            2'b01:   occupancy <= occupancy - OW'(1);
            default: occupancy <= occupancy;
         endcase
         if (enq && do_swap && (swap_count != 16'hFFFF)) swap_count <= swap_count + 16'd1;
      end
   end

   // Storage needs no reset: ostream_msg is masked to zero whenever occupancy is zero.
   always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= ordered;
   end

endmodule

// File: tb/tb_lab1_imul_operand_sorter.sv
// Bench for lab1_imul_operand_sorter: directed vector table, hand-written full/reset
// sequences, and randomized traffic checked against a queue-based reference model.
module tb_lab1_imul_operand_sorter;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   lab1_imul_operand_sorter_if if_a ();
   lab1_imul_operand_sorter_if if_b ();

   logic [1:0]  occ_a;
   logic [2:0]  occ_b;
   logic [15:0] swc_a;
   logic [15:0] swc_b;

   lab1_imul_operand_sorter #(.NENTRIES(2), .SWAP_EN(1'b1)) dut_a (
      .clk(clk), .reset(reset), .s(if_a), .occupancy(occ_a), .swap_count(swc_a)
   );

   lab1_imul_operand_sorter #(.NENTRIES(4), .SWAP_EN(1'b0)) dut_b (
      .clk(clk), .reset(reset), .s(if_b), .occupancy(occ_b), .swap_count(swc_b)
   );

   int n_checks = 0;
   int n_fail   = 0;

   logic [63:0] exp_q_a[$];
   logic [63:0] exp_q_b[$];
   int          exp_sw_a = 0;
   int          exp_sw_b = 0;

   bit          m_irdy_a, m_oval_a, m_irdy_b, m_oval_b;
   logic [63:0] m_head_a, m_head_b;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [63:0] exp_msg;
      bit          exp_swap;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Leading-one position via logarithm: msb(0) = -1.
   function automatic int msb_model(input logic [31:0] x);
      return $clog2({1'b0, x} + 33'd1) - 1;
   endfunction

   function automatic bit model_swaps(input logic [63:0] msg, input bit en);
      return en && (msb_model(msg[31:0]) > msb_model(msg[63:32]));
   endfunction

   function automatic logic [63:0] model_order(input logic [63:0] msg, input bit en);
      return model_swaps(msg, en) ? {msg[31:0], msg[63:32]} : msg;
   endfunction

   function automatic logic [31:0] rnd_op();
      return $urandom >> $urandom_range(0, 32);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: every negedge compares all outputs to the model, then applies the
   // transfers the model expects on the coming posedge.
   always @(negedge clk) begin
      m_irdy_a = reset && (exp_q_a.size() != 2);
      m_oval_a = (exp_q_a.size() != 0);
      m_head_a = m_oval_a ? exp_q_a[0] : 64'h0;
      check("a_occupancy",   64'(occ_a), 64'(exp_q_a.size()));
      check("a_istream_rdy", 64'(if_a.istream_rdy), 64'(m_irdy_a));
      check("a_ostream_val", 64'(if_a.ostream_val), 64'(m_oval_a));
      check("a_ostream_msg", if_a.ostream_msg, m_head_a);
      check("a_swap_count",  64'(swc_a), 64'(exp_sw_a));
      if (m_oval_a && if_a.ostream_rdy) void'(exp_q_a.pop_front());
      if (m_irdy_a && if_a.istream_val) begin
         exp_q_a.push_back(model_order(if_a.istream_msg, 1'b1));
         if (model_swaps(if_a.istream_msg, 1'b1) && exp_sw_a < 65535) exp_sw_a++;
      end

      m_irdy_b = reset && (exp_q_b.size() != 4);
      m_oval_b = (exp_q_b.size() != 0);
      m_head_b = m_oval_b ? exp_q_b[0] : 64'h0;
      check("b_occupancy",   64'(occ_b), 64'(exp_q_b.size()));
      check("b_istream_rdy", 64'(if_b.istream_rdy), 64'(m_irdy_b));
      check("b_ostream_val", 64'(if_b.ostream_val), 64'(m_oval_b));
      check("b_ostream_msg", if_b.ostream_msg, m_head_b);
      check("b_swap_count",  64'(swc_b), 64'(exp_sw_b));
      if (m_oval_b && if_b.ostream_rdy) void'(exp_q_b.pop_front());
      if (m_irdy_b && if_b.istream_val) begin
         exp_q_b.push_back(model_order(if_b.istream_msg, 1'b0));
         if (model_swaps(if_b.istream_msg, 1'b0) && exp_sw_b < 65535) exp_sw_b++;
      end
   end

   initial begin
      logic [63:0] m [3];
      int tbl_sw;

      vecs[0] = '{32'h00000003, 32'h80000000, 64'h80000000_00000003, 1'b1};
      vecs[1] = '{32'h00000010, 32'h00000010, 64'h00000010_00000010, 1'b0};
      vecs[2] = '{32'h00000000, 32'h00000005, 64'h00000005_00000000, 1'b1};
      vecs[3] = '{32'h00000007, 32'h00000000, 64'h00000007_00000000, 1'b0};
      vecs[4] = '{32'h00000000, 32'h00000000, 64'h00000000_00000000, 1'b0};
      vecs[5] = '{32'hFFFFFFFF, 32'h80000000, 64'hFFFFFFFF_80000000, 1'b0};
      vecs[6] = '{32'h00000001, 32'h00000002, 64'h00000002_00000001, 1'b1};
      vecs[7] = '{32'h00000040, 32'h0000007F, 64'h00000040_0000007F, 1'b0};

      if_a.istream_val = 1'b0; if_a.istream_msg = '0; if_a.ostream_rdy = 1'b0;
      if_b.istream_val = 1'b0; if_b.istream_msg = '0; if_b.ostream_rdy = 1'b0;
      reset = 1'b1;
      #1 reset = 1'b0;
      repeat (2) tick();

      check("rst_istream_rdy", 64'(if_a.istream_rdy), 64'(0));
      check("rst_ostream_val", 64'(if_a.ostream_val), 64'(0));
      check("rst_ostream_msg", if_a.ostream_msg, 64'h0);
      check("rst_occupancy",   64'(occ_a), 64'(0));
      check("rst_swap_count",  64'(swc_a), 64'(0));
      reset = 1'b1;
      #1;
      check("post_rst_istream_rdy", 64'(if_a.istream_rdy), 64'(1));

      // Directed vector table, one request at a time with the sink ready.
      tbl_sw = 0;
      if_a.ostream_rdy = 1'b1;
      for (int i = 0; i < 8; i++) begin
         if_a.istream_val = 1'b1;
         if_a.istream_msg = {vecs[i].a, vecs[i].b};
         tick();
         if_a.istream_val = 1'b0;
         if_a.istream_msg = {$urandom, $urandom};
         check("tbl_ostream_val", 64'(if_a.ostream_val), 64'(1));
         check("tbl_ostream_msg", if_a.ostream_msg, vecs[i].exp_msg);
         tbl_sw += int'(vecs[i].exp_swap);
         check("tbl_swap_count", 64'(swc_a), 64'(tbl_sw));
         tick();
         check("tbl_drained", 64'(occ_a), 64'(0));
      end

      // Fill a 2-deep queue with a stalled sink, offer a third request, then release.
      m[0] = 64'h00000003_00000100;
      m[1] = 64'h00000055_00000011;
      m[2] = 64'h00000000_0000ABCD;
      if_a.ostream_rdy = 1'b0;
      if_a.istream_val = 1'b1;
      for (int i = 0; i < 3; i++) begin
         if_a.istream_msg = m[i];
         tick();
      end
      check("full_occupancy",   64'(occ_a), 64'(2));
      check("full_istream_rdy", 64'(if_a.istream_rdy), 64'(0));
      check("full_head",        if_a.ostream_msg, 64'h00000100_00000003);
      tick();
      check("full_head_held",   if_a.ostream_msg, 64'h00000100_00000003);
      check("full_still_full",  64'(occ_a), 64'(2));
      if_a.ostream_rdy = 1'b1;
      tick();
      check("drain1_msg", if_a.ostream_msg, 64'h00000055_00000011);
      check("drain1_occ", 64'(occ_a), 64'(1));
      tick();
      if_a.istream_val = 1'b0;
      check("drain2_msg", if_a.ostream_msg, 64'h0000ABCD_00000000);
      check("drain2_occ", 64'(occ_a), 64'(1));
      tick();
      check("drain3_occ", 64'(occ_a), 64'(0));

      // Reset pulsed between clock edges with one entry queued.
      if_a.ostream_rdy = 1'b0;
      if_a.istream_val = 1'b1;
      if_a.istream_msg = 64'h00000001_00000F00;
      tick();
      if_a.istream_val = 1'b0;
      check("pre_pulse_occ", 64'(occ_a), 64'(1));
      #2;
      reset = 1'b0;
      exp_q_a.delete(); exp_q_b.delete();
      exp_sw_a = 0; exp_sw_b = 0;
      #1;
      check("pulse_ostream_val", 64'(if_a.ostream_val), 64'(0));
      check("pulse_occupancy",   64'(occ_a), 64'(0));
      check("pulse_swap_count",  64'(swc_a), 64'(0));
      check("pulse_ostream_msg", if_a.ostream_msg, 64'h0);
      reset = 1'b1;
      tick();

      // SWAP_EN=0 instance never reorders.
      if_b.istream_val = 1'b1;
      if_b.istream_msg = 64'h00000001_FFFFFFFF;
      tick();
      if_b.istream_val = 1'b0;
      check("noswap_msg",        if_b.ostream_msg, 64'h00000001_FFFFFFFF);
      check("noswap_swap_count", 64'(swc_b), 64'(0));
      if_b.ostream_rdy = 1'b1;
      tick();

      // Randomized traffic on both instances.
      for (int i = 0; i < 600; i++) begin
         if_a.istream_val = 1'($urandom_range(0, 1));
         if_a.istream_msg = {rnd_op(), rnd_op()};
         if_a.ostream_rdy = ($urandom_range(0, 3) != 0);
         if_b.istream_val = 1'($urandom_range(0, 1));
         if_b.istream_msg = {rnd_op(), rnd_op()};
         if_b.ostream_rdy = ($urandom_range(0, 2) != 0);
         tick();
      end
      if_a.istream_val = 1'b0; if_a.ostream_rdy = 1'b1;
      if_b.istream_val = 1'b0; if_b.ostream_rdy = 1'b1;
      repeat (6) tick();
      check("rand_drained_a", 64'(occ_a), 64'(0));
      check("rand_drained_b", 64'(occ_b), 64'(0));

      // Stream swapped requests past the counter limit.
      if_a.istream_val = 1'b1;
      if_a.istream_msg = 64'h00000001_00000002;
      repeat (65540) tick();
      if_a.istream_val = 1'b0;
      repeat (3) tick();
      check("swap_count_saturated", 64'(swc_a), 64'(16'hFFFF));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
